// File: rtl/merge_stage.sv
// merge_stage: merges the a-path and b-path Send/Ack packet streams through a
// DEPTH-entry FIFO into one registered Send/Ack output, in acceptance order.
module merge_stage #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic                   CP,
    input  logic                   MR_n,
    input  logic [WIDTH-1:0]       PACKET_IN_A,
    input  logic                   Send_in_a,
    output logic                   Ack_out_a,
    input  logic [WIDTH-1:0]       PACKET_IN_B,
    input  logic                   Send_in_b,
    output logic                   Ack_out_b,
    output logic [WIDTH-1:0]       PACKET_OUT,
    output logic                   Send_out,
    input  logic                   Ack_in,
    output logic [$clog2(DEPTH):0] Count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {I_IDLE, I_ACK} in_state_t;
    typedef enum logic [1:0] {O_IDLE, O_SEND, O_WAIT} out_state_t;

    in_state_t        a_q, b_q;
    out_state_t       o_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] out_q;
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q;
    logic             send_q, prio_q;
    logic             elig_a, elig_b, full, gnt_a, gnt_b, wr, pop;

    assign elig_a = a_q == I_IDLE && Send_in_a;
    assign elig_b = b_q == I_IDLE && Send_in_b;
    assign full   = count_q == (AW+1)'(DEPTH);
    // prio_q=0 favours a on a tie; it flips to the loser after each contested grant
    assign gnt_a  = !full && elig_a && (!elig_b || !prio_q);
    assign gnt_b  = !full && elig_b && (!elig_a || prio_q);
    assign wr     = gnt_a || gnt_b;
    assign pop    = o_q == O_IDLE && count_q != '0;

    always_ff @(posedge CP) begin
        if (wr) mem_q[wr_q] <= gnt_a ? PACKET_IN_A : PACKET_IN_B;
    end

    always_ff @(posedge CP or negedge MR_n) begin
        if (!MR_n) begin
            a_q     <= I_IDLE;
            b_q     <= I_IDLE;
            o_q     <= O_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            out_q   <= '0;
            send_q  <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            a_q     <= gnt_a ? I_ACK : (a_q == I_ACK && !Send_in_a) ? I_IDLE : a_q;
            b_q     <= gnt_b ? I_ACK : (b_q == I_ACK && !Send_in_b) ? I_IDLE : b_q;
            prio_q  <= (elig_a && elig_b && wr) ? gnt_a : prio_q;
            wr_q    <= wr ? wr_q + AW'(1) : wr_q;
            count_q <= count_q + (AW+1)'(wr) - (AW+1)'(pop);
            case (o_q)
                O_IDLE: if (pop) begin
                    out_q  <= mem_q[rd_q];
                    rd_q   <= rd_q + AW'(1);
                    send_q <= 1'b1;
                    o_q    <= O_SEND;
                end
                O_SEND: if (Ack_in) begin
                    send_q <= 1'b0;
                    o_q    <= O_WAIT;
                end
                O_WAIT: if (!Ack_in) o_q <= O_IDLE;
                default: o_q <= O_IDLE;
            endcase
        end
    end

    assign Ack_out_a  = a_q == I_ACK;
    assign Ack_out_b  = b_q == I_ACK;
    assign PACKET_OUT = out_q;
    assign Send_out   = send_q;
    assign Count      = count_q;
endmodule
